// File: rtl/sprite_anim_sel.sv
// Direction pad to sprite-sheet row/column selector with a timed walk cycle.
// Optional macro SPRITE_MIRROR_LR_EN: left reuses the right row and requests hflip.
// state | meaning
// IDLE  | no valid direction; standing pose (frame 0)
// WALK  | valid one-hot direction held; frames advance on frame_tick
module sprite_anim_sel #(
  parameter int TILE       = 16,
  parameter int FRAMES     = 4,
  parameter int HOLD_TICKS = 8,
  parameter int OFFW       = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      dir_in,
  input  logic            frame_tick,
  output logic [OFFW-1:0] hoffset,
  output logic [OFFW-1:0] voffset,
  output logic            moving,
  output logic            hflip
);

  localparam int TW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WALK = 1'b1;

  if (FRAMES < 2 || HOLD_TICKS < 1 ||
      longint'(FRAMES - 1) * TILE >= (longint'(1) << OFFW) ||
      longint'(3) * TILE >= (longint'(1) << OFFW)) begin : g_param_err
    $error("sprite_anim_sel: illegal FRAMES/HOLD_TICKS/TILE/OFFW combination");
  end

  logic [0:0]    state, state_nxt;
  logic [1:0]    row_idx, row_nxt, row_dec;
  logic [3:0]    dir_q, dir_nxt;
  logic [FW-1:0] frame_idx, frame_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic          hflip_nxt, hflip_dec, valid;

  always_comb begin
    valid     = $onehot(dir_in);
    row_dec   = 2'd0;
    hflip_dec = 1'b0;
    case (dir_in)
      4'b1000: row_dec = 2'd1;
      4'b0100: row_dec = 2'd0;
`ifdef SPRITE_MIRROR_LR_EN
      4'b0010: begin
        row_dec   = 2'd3;
        hflip_dec = 1'b1;
      end
`else
      4'b0010: row_dec = 2'd2;
`endif
      4'b0001: row_dec = 2'd3;
      default: row_dec = 2'd0;
    endcase

    state_nxt = state;
    row_nxt   = row_idx;
    hflip_nxt = hflip;
    dir_nxt   = dir_q;
    frame_nxt = frame_idx;
    tick_nxt  = tick_cnt;

    if (!valid) begin
      state_nxt = IDLE;
      frame_nxt = '0;
      tick_nxt  = '0;
    end else if (state == IDLE || dir_in != dir_q) begin
      // A tick arriving with a direction change is dropped on purpose.
      state_nxt = WALK;
      row_nxt   = row_dec;
      hflip_nxt = hflip_dec;
      dir_nxt   = dir_in;
      frame_nxt = '0;
      tick_nxt  = '0;
    end else if (frame_tick) begin
      if (tick_cnt == TW'(HOLD_TICKS - 1)) begin
        tick_nxt  = '0;
        frame_nxt = (frame_idx == FW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
        tick_nxt = tick_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_idx   <= 2'd0;
      hflip     <= 1'b0;
      dir_q     <= 4'd0;
      frame_idx <= '0;
      tick_cnt  <= '0;
      moving    <= 1'b0;
      hoffset   <= '0;
      voffset   <= '0;
    end else begin
      state     <= state_nxt;
      row_idx   <= row_nxt;
      hflip     <= hflip_nxt;
      dir_q     <= dir_nxt;
      frame_idx <= frame_nxt;
      tick_cnt  <= tick_nxt;
      moving    <= valid;
      hoffset   <= OFFW'(32'(frame_nxt) * 32'(TILE));
      voffset   <= OFFW'(32'(row_nxt) * 32'(TILE));
    end
  end

endmodule

// File: tb/tb_sprite_anim_sel.sv
// Scoreboard bench for sprite_anim_sel (TILE=16, FRAMES=4, HOLD_TICKS=2).
// Honours SPRITE_MIRROR_LR_EN the same way the design build does.
module tb_sprite_anim_sel;

  localparam int TILE = 16;
  localparam int FRAMES = 4;
  localparam int HOLD = 2;
  localparam int OFFW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      dir_in;
  logic            frame_tick;
  logic [OFFW-1:0] hoffset, voffset;
  logic            moving, hflip;

  sprite_anim_sel #(.TILE(TILE), .FRAMES(FRAMES), .HOLD_TICKS(HOLD), .OFFW(OFFW)) dut (
    .clk(clk), .rst_n(rst_n), .dir_in(dir_in), .frame_tick(frame_tick),
    .hoffset(hoffset), .voffset(voffset), .moving(moving), .hflip(hflip)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            mv;
    logic            hf;
    logic [OFFW-1:0] vo;
    logic [OFFW-1:0] ho;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: ticks counted since the current direction started
  logic       m_walk;
  logic [3:0] m_dir;
  int         m_cnt;
  int         m_row;
  logic       m_hf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_walk = 0; m_dir = 0; m_cnt = 0; m_row = 0; m_hf = 0;
  endtask

  task automatic step(input logic [3:0] d, input logic t);
    exp_t e, g;
    @(negedge clk);
    dir_in = d;
    frame_tick = t;
    if ($countones(d) != 1) begin
      m_walk = 0;
      m_cnt = 0;
    end else if (!m_walk || d != m_dir) begin
      m_walk = 1;
      m_dir = d;
      m_cnt = 0;
      m_hf = 0;
      if (d == 4'b1000) m_row = 1;
      else if (d == 4'b0100) m_row = 0;
      else if (d == 4'b0001) m_row = 3;
      else begin
`ifdef SPRITE_MIRROR_LR_EN
        m_row = 3;
        m_hf = 1;
`else
        m_row = 2;
`endif
      end
    end else if (t) begin
      m_cnt++;
    end
    e.mv = ($countones(d) == 1);
    e.hf = m_hf;
    e.vo = OFFW'(m_row * TILE);
    e.ho = OFFW'(((m_cnt / HOLD) % FRAMES) * TILE);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      g = '{mv: moving, hf: hflip, vo: voffset, ho: hoffset};
      check("sb_moving", 32'(g.mv), 32'(e.mv));
      check("sb_hflip", 32'(g.hf), 32'(e.hf));
      check("sb_voffset", 32'(g.vo), 32'(e.vo));
      check("sb_hoffset", 32'(g.ho), 32'(e.ho));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dir_in = 4'b0000;
    frame_tick = 1'b0;
    model_reset();
    #23;
    check("rst_hoffset", 32'(hoffset), 0);
    check("rst_voffset", 32'(voffset), 0);
    check("rst_moving", 32'(moving), 0);
    check("rst_hflip", 32'(hflip), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // down held, no ticks
    step(4'b0100, 0);
    step(4'b0100, 0);
    check("down_moving", 32'(moving), 1);
    check("down_voffset", 32'(voffset), 0);
    check("down_hoffset", 32'(hoffset), 0);

    // right with 8 ticks: steps every 2 ticks and wraps
    step(4'b0001, 0);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0001, 1);
      if (k == 2) check("walk_k2", 32'(hoffset), 16);
      if (k == 4) check("walk_k4", 32'(hoffset), 32);
      if (k == 6) check("walk_k6", 32'(hoffset), 48);
      step(4'b0001, 0);
    end
    check("walk_wrap", 32'(hoffset), 0);
    check("walk_voffset", 32'(voffset), 48);

    // reach 32, then switch to up with a coincident tick
    for (int k = 0; k < 4; k++) step(4'b0001, 1);
    check("pre_switch", 32'(hoffset), 32);
    step(4'b1000, 1);
    check("switch_voffset", 32'(voffset), 16);
    check("switch_hoffset", 32'(hoffset), 0);
    step(4'b1000, 1);
    check("switch_t1", 32'(hoffset), 0);
    step(4'b1000, 1);
    check("switch_t2", 32'(hoffset), 16);

    // invalid patterns go idle
    step(4'b1010, 0);
    check("multi_moving", 32'(moving), 0);
    check("multi_hoffset", 32'(hoffset), 0);
    check("multi_voffset", 32'(voffset), 16);
    step(4'b1010, 1);
    step(4'b0000, 1);
    step(4'b0000, 1);
    check("idle_hoffset", 32'(hoffset), 0);

    // left row selection
    step(4'b0010, 0);
`ifdef SPRITE_MIRROR_LR_EN
    check("left_voffset", 32'(voffset), 48);
    check("left_hflip", 32'(hflip), 1);
`else
    check("left_voffset", 32'(voffset), 32);
    check("left_hflip", 32'(hflip), 0);
`endif
    step(4'b0000, 0);
    step(4'b0001, 0);
    check("right_hflip", 32'(hflip), 0);

    // random mix
    for (int i = 0; i < 60; i++) begin
      logic [3:0] d;
      case ($urandom_range(0, 5))
        0: d = 4'b1000;
        1: d = 4'b0100;
        2: d = 4'b0010;
        3, 4: d = dir_in;
        default: d = 4'($urandom_range(0, 15));
      endcase
      step(d, 1'($urandom_range(0, 1)));
    end

    // async reset between clock edges mid-walk
    step(4'b0001, 0);
    for (int k = 0; k < 3; k++) step(4'b0001, 1);
    check("pre_reset_hoffset", 32'(hoffset), 16);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    dir_in = 4'b0000;
    frame_tick = 1'b0;
    #1;
    check("async_hoffset", 32'(hoffset), 0);
    check("async_voffset", 32'(voffset), 0);
    check("async_moving", 32'(moving), 0);
    check("async_hflip", 32'(hflip), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 1);
    step(4'b0000, 0);
    check("post_rst_moving", 32'(moving), 0);
    step(4'b0001, 0);
    check("post_rst_voffset", 32'(voffset), 48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
